hvac_zone_scheduler: RTL and testbench

Time-shares one heating/cooling plant between NZONES thermal zones. Each zone reports a 5-bit temperature. The scheduler grants the plant to one zone at a time with round-robin fairness, enforces a minimum on-time, a maximum on-time under contention and a mandatory plant rest period, and drives the heating/cooling enables plus the selected zone. It sits above the single-zone air-conditioning controller level and replaces per-zone plant ownership.

---
 rtl/hvac_zone_scheduler.sv | 156 +++++++++++++++
 tb/tb_hvac_zone_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hvac_zone_scheduler.sv
// hvac_zone_scheduler: shares one heating/cooling plant between NZONES zones.
// Round-robin grants with a minimum on-time, a contention cap on on-time and a
// fixed plant rest period between grants. All outputs are registered.
module hvac_zone_scheduler #(
    parameter int unsigned NZONES = 4,
    parameter int unsigned MIN_ON = 8,
    parameter int unsigned MAX_ON = 32,
    parameter int unsigned REST   = 4,
    parameter int unsigned ZW     = $clog2(NZONES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5*NZONES-1:0] temperature,
    output logic                heating,
    output logic                cooling,
    output logic [ZW-1:0]       zone,
    output logic                zone_valid,
    output logic                resting
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StRest = 2'd2;

    localparam int unsigned CW = $clog2(MAX_ON + 1);
    localparam int unsigned RW = $clog2(REST + 1);

    localparam logic [CW-1:0] MinOnLast = CW'(MIN_ON - 1);
    localparam logic [CW-1:0] MaxOnLast = CW'(MAX_ON - 1);
    localparam logic [CW-1:0] MaxOnSat  = CW'(MAX_ON);
    localparam logic [RW-1:0] RestLast  = RW'(REST - 1);

    logic [1:0]        state_q, state_d;
    logic [ZW-1:0]     zone_q, zone_d;
    logic [ZW-1:0]     ptr_q, ptr_d;
    logic              mode_heat_q, mode_heat_d;
    logic [CW-1:0]     on_cnt_q, on_cnt_d;
    logic [RW-1:0]     rest_cnt_q, rest_cnt_d;

    logic [NZONES-1:0] heat_req, cool_req, any_req;
    logic              win_found;
    logic [ZW-1:0]     win_zone;
    logic [ZW-1:0]     cand;
    logic [4:0]        t_zone;
    logic              satisfied;
    logic              others_req;
    logic              grant;

    // Per-zone requests from the hysteresis band (19..21 requests nothing)
    always_comb begin
        heat_req = '0;
        cool_req = '0;
        for (int i = 0; i < int'(NZONES); i++) begin
            heat_req[i] = (temperature[5*i +: 5] <= 5'd18);
            cool_req[i] = (temperature[5*i +: 5] >= 5'd22);
        end
    end

    assign any_req = heat_req | cool_req;

    // Round-robin winner: first requester searching upward from ptr+1, wrapping
    always_comb begin
        win_found = 1'b0;
        win_zone  = '0;
        cand      = '0;
        for (int i = 1; i <= int'(NZONES); i++) begin
            cand = ZW'((int'(ptr_q) + i) % int'(NZONES));
            if (!win_found && any_req[cand]) begin
                win_found = 1'b1;
                win_zone  = cand;
            end
        end
    end

    assign t_zone     = temperature[5*zone_q +: 5];
    assign satisfied  = mode_heat_q ? (t_zone >= 5'd20) : (t_zone <= 5'd20);
    assign others_req = |(any_req & ~(NZONES'(1) << zone_q));

    // Next-state: grant, on-time accounting and rest countdown
    always_comb begin
        state_d     = state_q;
        zone_d      = zone_q;
        ptr_d       = ptr_q;
        mode_heat_d = mode_heat_q;
        on_cnt_d    = on_cnt_q;
        rest_cnt_d  = rest_cnt_q;
        grant       = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_found) grant = 1'b1;
            end
            StRun: begin
                if (on_cnt_q != MaxOnSat) on_cnt_d = on_cnt_q + 1'b1;
                if ((on_cnt_q >= MinOnLast && satisfied) ||
                    (on_cnt_q >= MaxOnLast && others_req)) begin
                    state_d    = StRest;
                    rest_cnt_d = '0;
                end
            end
            StRest: begin
                if (rest_cnt_q == RestLast) begin
                    if (win_found) grant = 1'b1;
                    else           state_d = StIdle;
                end else begin
                    rest_cnt_d = rest_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // A grant from IDLE or from the last REST cycle loads a fresh RUN
        if (grant) begin
            state_d     = StRun;
            zone_d      = win_zone;
            ptr_d       = win_zone;
            mode_heat_d = heat_req[win_zone];
            on_cnt_d    = '0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            zone_q      <= '0;
            ptr_q       <= ZW'(NZONES - 1);
            mode_heat_q <= 1'b0;
            on_cnt_q    <= '0;
            rest_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            zone_q      <= zone_d;
            ptr_q       <= ptr_d;
            mode_heat_q <= mode_heat_d;
            on_cnt_q    <= on_cnt_d;
            rest_cnt_q  <= rest_cnt_d;
        end
    end

    // Output registers decoded from the next state so they align with state_q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            heating    <= 1'b0;
            cooling    <= 1'b0;
            zone_valid <= 1'b0;
            resting    <= 1'b0;
        end else begin
            heating    <= (state_d == StRun) && mode_heat_d;
            cooling    <= (state_d == StRun) && !mode_heat_d;
            zone_valid <= (state_d == StRun);
            resting    <= (state_d == StRest);
        end
    end

    assign zone = zone_q;

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Bench for hvac_zone_scheduler: vector table, directed multi-cycle sequences
// and a randomized run against a cycle-level reference model.
module tb_hvac_zone_scheduler;

    localparam int NZ     = 4;
    localparam int MIN_ON = 8;
    localparam int MAX_ON = 32;
    localparam int REST   = 4;

    logic            clk;
    logic            rst_n;
    logic [5*NZ-1:0] temperature;
    logic            heating, cooling, zone_valid, resting;
    logic [1:0]      zone;

    int total = 0;
    int bad   = 0;
    int tz[NZ];

    hvac_zone_scheduler #(
        .NZONES(NZ), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .REST(REST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .temperature(temperature),
        .heating    (heating),
        .cooling    (cooling),
        .zone       (zone),
        .zone_valid (zone_valid),
        .resting    (resting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 serving, 2 plant rest
    int m_phase, m_zone, m_ptr, m_run, m_rest;
    bit m_heat;

    function automatic bit wants_heat(int t);
        return t <= 18;
    endfunction

    function automatic bit wants_cool(int t);
        return t >= 22;
    endfunction

    function automatic int next_winner();
        for (int k = 1; k <= NZ; k++) begin
            int z;
            z = (m_ptr + k) % NZ;
            if (wants_heat(tz[z]) || wants_cool(tz[z])) return z;
        end
        return -1;
    endfunction

    task automatic model_grant();
        int w;
        w = next_winner();
        if (w < 0) begin
            m_phase = 0;
        end else begin
            m_phase = 1;
            m_zone  = w;
            m_ptr   = w;
            m_heat  = wants_heat(tz[w]);
            m_run   = 0;
        end
    endtask

    task automatic model_step();
        bit sat, others;
        if (!rst_n) begin
            m_phase = 0; m_zone = 0; m_ptr = NZ - 1; m_heat = 0; m_run = 0; m_rest = 0;
        end else if (m_phase == 0) begin
            model_grant();
        end else if (m_phase == 1) begin
            m_run++;
            sat    = m_heat ? (tz[m_zone] >= 20) : (tz[m_zone] <= 20);
            others = 0;
            for (int z = 0; z < NZ; z++)
                if (z != m_zone && (wants_heat(tz[z]) || wants_cool(tz[z]))) others = 1;
            if ((m_run >= MIN_ON && sat) || (m_run >= MAX_ON && others)) begin
                m_phase = 2;
                m_rest  = 0;
            end
        end else begin
            m_rest++;
            if (m_rest == REST) model_grant();
        end
    endtask

    task automatic set_t(input int a, input int b, input int c, input int d);
        tz[0] = a; tz[1] = b; tz[2] = c; tz[3] = d;
        for (int i = 0; i < NZ; i++) temperature[5*i +: 5] = 5'(tz[i]);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input bit h, input bit c, input bit v,
                         input int z, input bit r);
        logic [5:0] got, want;
        got  = {heating, cooling, zone_valid, zone, resting};
        want = {h, c, v, 2'(z), r};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s @%0t: got h=%b c=%b v=%b z=%0d r=%b, want h=%b c=%b v=%b z=%0d r=%b",
                     name, $time, heating, cooling, zone_valid, zone, resting, h, c, v, z, r);
        end
    endtask

    task automatic hold(input string name, input int n, input bit h, input bit c,
                        input bit v, input int z, input bit r);
        for (int i = 0; i < n; i++) begin
            step();
            check(name, h, c, v, z, r);
        end
    endtask

    typedef struct {
        string name;
        bit    rst;
        int    t0, t1, t2, t3;
        int    n;
        bit    h, c, v;
        int    z;
        bit    r;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0;
        set_t(10, 10, 10, 10);
        m_phase = 0; m_zone = 0; m_ptr = NZ - 1; m_heat = 0; m_run = 0; m_rest = 0;

        // name, rst_n, temps, cycles, expected h c v zone resting
        vecs.push_back('{"rst_hold",   1'b0, 10, 10, 10, 10, 3, 1'b0, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{"rst_grant",  1'b1, 10, 10, 10, 10, 1, 1'b1, 1'b0, 1'b1, 0, 1'b0});
        vecs.push_back('{"min_on_z0",  1'b1, 20, 20, 20, 20, 7, 1'b1, 1'b0, 1'b1, 0, 1'b0});
        vecs.push_back('{"rest_z0",    1'b1, 20, 20, 20, 20, 4, 1'b0, 1'b0, 1'b0, 0, 1'b1});
        vecs.push_back('{"idle_z0",    1'b1, 20, 20, 20, 20, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{"heat_z2",    1'b1, 20, 20, 15, 20, 3, 1'b1, 1'b0, 1'b1, 2, 1'b0});
        vecs.push_back('{"min_on_z2",  1'b1, 20, 20, 20, 20, 5, 1'b1, 1'b0, 1'b1, 2, 1'b0});
        vecs.push_back('{"rest_z2",    1'b1, 20, 20, 20, 20, 4, 1'b0, 1'b0, 1'b0, 2, 1'b1});
        vecs.push_back('{"idle_z2",    1'b1, 20, 20, 20, 20, 1, 1'b0, 1'b0, 1'b0, 2, 1'b0});
        vecs.push_back('{"cool_z1",    1'b1, 20, 25, 20, 20, 6, 1'b0, 1'b1, 1'b1, 1, 1'b0});
        vecs.push_back('{"rst_midrun", 1'b0, 25, 25, 20, 20, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0});
        vecs.push_back('{"restart_z0", 1'b1, 25, 25, 20, 20, 1, 1'b0, 1'b1, 1'b1, 0, 1'b0});
        vecs.push_back('{"rst_clean",  1'b0, 20, 20, 20, 20, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0});

        foreach (vecs[k]) begin
            rst_n = vecs[k].rst;
            set_t(vecs[k].t0, vecs[k].t1, vecs[k].t2, vecs[k].t3);
            hold(vecs[k].name, vecs[k].n, vecs[k].h, vecs[k].c, vecs[k].v, vecs[k].z,
                 vecs[k].r);
        end

        // Contention: two never-satisfied cooling zones alternate at MAX_ON
        rst_n = 1'b0;
        set_t(25, 25, 20, 20);
        step();
        rst_n = 1'b1;
        hold("cont_z0",    MAX_ON, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        hold("cont_rest1", REST,   1'b0, 1'b0, 1'b0, 0, 1'b1);
        hold("cont_z1",    MAX_ON, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        hold("cont_rest2", REST,   1'b0, 1'b0, 1'b0, 1, 1'b1);
        hold("cont_z0_again", 1,   1'b0, 1'b1, 1'b1, 0, 1'b0);

        // Wrap-around: ptr at 3 after reset, zones 1 and 3 request
        rst_n = 1'b0;
        set_t(20, 10, 20, 10);
        step();
        rst_n = 1'b1;
        hold("wrap_z1", 1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        set_t(20, 20, 20, 10);
        hold("wrap_z1_min", MIN_ON - 1, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        hold("wrap_rest",   REST,       1'b0, 1'b0, 1'b0, 1, 1'b1);
        hold("wrap_z3",     1,          1'b1, 1'b0, 1'b1, 3, 1'b0);

        // Mixed modes: heating zone 0 cut by cooling zone 1
        rst_n = 1'b0;
        set_t(12, 24, 20, 20);
        step();
        rst_n = 1'b1;
        hold("mix_z0_heat", MAX_ON, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        hold("mix_rest",    REST,   1'b0, 1'b0, 1'b0, 0, 1'b1);
        hold("mix_z1_cool", 3,      1'b0, 1'b1, 1'b1, 1, 1'b0);

        // Randomized run against the reference model
        rst_n = 1'b0;
        set_t(20, 20, 20, 20);
        step();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < NZ; i++)
                if ($urandom_range(0, 5) == 0) tz[i] = int'($urandom_range(14, 26));
            set_t(tz[0], tz[1], tz[2], tz[3]);
            step();
            check("rand_model", (m_phase == 1) && m_heat, (m_phase == 1) && !m_heat,
                  m_phase == 1, m_zone, m_phase == 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
